// File: rtl/axis_qbuff_sink_if.sv
// AXI4-Stream beat channel between the qualified buffer and its readout sink.
interface axis_qbuff_sink_if #(
  parameter int B = 16
);
  logic         tvalid;
  logic         tready;
  logic [B-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_qbuff_sink.sv
// Packet sink for the qualified-buffer readout path: captures one tlast-delimited
// packet per arm into a 2^N-deep sample memory, reports length/done/overflow and
// offers a registered, read-first random-access port into the captured samples.
module axis_qbuff_sink #(
  parameter int B = 16,
  parameter int N = 6
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_aresetn,
  axis_qbuff_sink_if.slave    s_axis,
  input  logic                arm,
  input  logic [N-1:0]        rd_addr,
  output logic [B-1:0]        rd_data,
  output logic                busy,
  output logic                done,
  output logic [N:0]          len,
  output logic                ovf
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

  localparam int          DEPTH    = 1 << N;
  localparam logic [N:0]  ONE      = (N+1)'(1);
  localparam logic [N:0]  FULL_LEN = {1'b1, {N{1'b0}}};
  localparam logic [N:0]  LAST_IDX = {1'b0, {N{1'b1}}};

  state_t       state, state_n;
  logic [N:0]   wptr, wptr_n;
  logic [N:0]   len_n;
  logic         ovf_n;
  logic         wr_en;
  logic         accept;

  logic [B-1:0] mem [DEPTH];

  // Handshake and status are pure decodes of the registered state.
  assign s_axis.tready = (state == RECV) || (state == DROP);
  assign busy          = (state == RECV) || (state == DROP);
  assign done          = (state == DONE);
  assign accept        = s_axis.tvalid && s_axis.tready;

  // Next-state, write-pointer and status update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
    state_n = state;
    wptr_n  = wptr;
    len_n   = len;
    ovf_n   = ovf;
    wr_en   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_n = RECV;
          wptr_n  = '0;
          len_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          wr_en  = 1'b1;
          wptr_n = wptr + ONE;
          if (s_axis.tlast) begin
            // An exactly-full packet ends here too and is not an overflow.
            len_n   = wptr + ONE;
            state_n = DONE;
          end else if (wptr == LAST_IDX) begin
            len_n   = FULL_LEN;
            ovf_n   = 1'b1;
            state_n = DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_axis.tlast) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state <= IDLE;
      wptr  <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_n;
      wptr  <= wptr_n;
      len   <= len_n;
      ovf   <= ovf_n;
    end
  end

  // Sample memory write port.
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: the memory has no reset; only addresses below len are ever meaningful.
    if (wr_en) begin
      mem[wptr[N-1:0]] <= s_axis.tdata;
    end
  end

  // Registered read port; reads old data when the same address is written on this edge.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axis_qbuff_sink.sv
// Directed bench for axis_qbuff_sink: a 64-deep instance for normal, gapped,
// single-beat and reset-mid-packet captures, and an 8-deep instance for
// overflow, exactly-full and arm-held-high behaviour.
module tb_axis_qbuff_sink;

  logic        clk;
  logic        rst_n;
  logic        arm6, arm3;
  logic [5:0]  rd_addr6;
  logic [2:0]  rd_addr3;
  logic [15:0] rd_data6, rd_data3;
  logic        busy6, busy3, done6, done3, ovf6, ovf3;
  logic [6:0]  len6;
  logic [3:0]  len3;

  int checks   = 0;
  int failures = 0;

  axis_qbuff_sink_if #(.B(16)) ax6 ();
  axis_qbuff_sink_if #(.B(16)) ax3 ();

  axis_qbuff_sink #(.B(16), .N(6)) dut6 (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (ax6),
    .arm            (arm6),
    .rd_addr        (rd_addr6),
    .rd_data        (rd_data6),
    .busy           (busy6),
    .done           (done6),
    .len            (len6),
    .ovf            (ovf6)
  );

  axis_qbuff_sink #(.B(16), .N(3)) dut3 (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (ax3),
    .arm            (arm3),
    .rd_addr        (rd_addr3),
    .rd_data        (rd_data3),
    .busy           (busy3),
    .done           (done3),
    .len            (len3),
    .ovf            (ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to the selected sink and hold it until it is accepted.
  task automatic send(input bit to3, input logic [15:0] d, input logic last, input bit gap);
    int   n = 0;
    logic rdy;
    if (to3) begin
      ax3.tvalid = 1'b1; ax3.tdata = d; ax3.tlast = last;
    end else begin
      ax6.tvalid = 1'b1; ax6.tdata = d; ax6.tlast = last;
    end
    rdy = to3 ? ax3.tready : ax6.tready;
    while (rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
      rdy = to3 ? ax3.tready : ax6.tready;
    end
    if (rdy !== 1'b1) check("ready_timeout", 32'(rdy), 1);
    tick();
    if (to3) begin
      ax3.tvalid = 1'b0; ax3.tlast = 1'b0;
    end else begin
      ax6.tvalid = 1'b0; ax6.tlast = 1'b0;
    end
    if (gap && !last) begin
      check("ready_in_gap", 32'(to3 ? ax3.tready : ax6.tready), 1);
      tick();
    end
  endtask

  task automatic read6(input logic [5:0] a, input logic [15:0] exp);
    rd_addr6 = a;
    tick();
    check($sformatf("mem6[%0d]", a), 32'(rd_data6), 32'(exp));
  endtask

  task automatic read3(input logic [2:0] a, input logic [15:0] exp);
    rd_addr3 = a;
    tick();
    check($sformatf("mem3[%0d]", a), 32'(rd_data3), 32'(exp));
  endtask

  initial begin
    logic [15:0] pkt [4];
    int bad;
    pkt[0] = 16'd100; pkt[1] = 16'd200; pkt[2] = 16'd300; pkt[3] = 16'd400;

    rst_n = 1'b1;
    arm6 = 1'b1; arm3 = 1'b1;
    rd_addr6 = '0; rd_addr3 = '0;
    ax6.tvalid = 1'b1; ax6.tdata = 16'h1234; ax6.tlast = 1'b0;
    ax3.tvalid = 1'b1; ax3.tdata = 16'h5678; ax3.tlast = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with tvalid and arm high: nothing may move.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_tready6", 32'(ax6.tready), 0);
      if (busy6 || done6 || ovf6 || len6 != 0 || rd_data6 != 0) bad++;
      if (ax3.tready || busy3 || done3 || ovf3 || len3 != 0 || rd_data3 != 0) bad++;
    end
    check("rst_outputs_nonzero_cycles", 32'(bad), 0);

    arm6 = 1'b0; arm3 = 1'b0;
    ax6.tvalid = 1'b0; ax3.tvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_tready", 32'(ax6.tready), 0);
    check("idle_done", 32'(done6), 0);

    // Arm then a 4-beat back-to-back packet.
    arm6 = 1'b1;
    tick();
    arm6 = 1'b0;
    check("arm_to_ready", 32'(ax6.tready), 1);
    check("arm_busy", 32'(busy6), 1);
    for (int i = 0; i < 4; i++) send(1'b0, pkt[i], i == 3, 1'b0);
    check("p1_done", 32'(done6), 1);
    check("p1_len", 32'(len6), 4);
    check("p1_ovf", 32'(ovf6), 0);
    check("p1_tready_after_last", 32'(ax6.tready), 0);
    check("p1_busy_after_last", 32'(busy6), 0);
    for (int i = 0; i < 4; i++) read6(6'(i), pkt[i]);
    check("p1_done_holds", 32'(done6), 1);

    // Same packet with tvalid gaps, arm pulsed mid-packet (must be ignored).
    arm6 = 1'b1;
    tick();
    arm6 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) arm6 = 1'b1;
      send(1'b0, pkt[i], i == 3, 1'b1);
      arm6 = 1'b0;
    end
    check("p2_done", 32'(done6), 1);
    check("p2_len", 32'(len6), 4);
    check("p2_ovf", 32'(ovf6), 0);
    for (int i = 0; i < 4; i++) read6(6'(i), pkt[i]);

    // From DONE: single negative beat.
    arm6 = 1'b1;
    tick();
    arm6 = 1'b0;
    check("p3_done_dropped", 32'(done6), 0);
    send(1'b0, 16'hFFF9, 1'b1, 1'b0);
    check("p3_len", 32'(len6), 1);
    check("p3_ovf", 32'(ovf6), 0);
    check("p3_done", 32'(done6), 1);
    read6(6'd0, 16'hFFF9);
    read6(6'd1, 16'd200);

    // 8-deep sink: 11-beat packet overflows.
    arm3 = 1'b1;
    tick();
    arm3 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      send(1'b1, 16'(i), i == 11, 1'b0);
      if (i == 8) begin
        check("ovf_len_at_8", 32'(len3), 8);
        check("ovf_flag_at_8", 32'(ovf3), 1);
        check("ovf_busy_drop", 32'(busy3), 1);
      end
      if (i == 10) check("ovf_tready_drop", 32'(ax3.tready), 1);
    end
    check("ovf_done", 32'(done3), 1);
    check("ovf_len", 32'(len3), 8);
    check("ovf_flag", 32'(ovf3), 1);
    check("ovf_tready_after_last", 32'(ax3.tready), 0);
    for (int i = 0; i < 8; i++) read3(3'(i), 16'(i + 1));

    // 8-deep sink: exactly-full packet is not an overflow.
    arm3 = 1'b1;
    tick();
    arm3 = 1'b0;
    check("full_ovf_cleared", 32'(ovf3), 0);
    for (int i = 0; i < 8; i++) send(1'b1, 16'(21 + i), i == 7, 1'b0);
    check("full_len", 32'(len3), 8);
    check("full_ovf", 32'(ovf3), 0);
    check("full_done", 32'(done3), 1);
    read3(3'd7, 16'd28);

    // Arm held high: DONE lasts exactly one cycle.
    arm3 = 1'b1;
    tick();
    send(1'b1, 16'd30, 1'b0, 1'b0);
    send(1'b1, 16'd31, 1'b1, 1'b0);
    check("hold_done", 32'(done3), 1);
    check("hold_len", 32'(len3), 2);
    tick();
    check("hold_done_one_cycle", 32'(done3), 0);
    check("hold_rearmed_busy", 32'(busy3), 1);
    check("hold_len_cleared", 32'(len3), 0);
    arm3 = 1'b0;

    // Reset in the middle of a 5-beat packet, with no clock edge.
    arm6 = 1'b1;
    tick();
    arm6 = 1'b0;
    rd_addr6 = 6'd0;
    send(1'b0, 16'd1, 1'b0, 1'b0);
    send(1'b0, 16'd2, 1'b0, 1'b0);
    check("pre_rst_rd_data", 32'(rd_data6), 1);
    ax6.tvalid = 1'b1; ax6.tdata = 16'd3; ax6.tlast = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_tready", 32'(ax6.tready), 0);
    check("async_busy", 32'(busy6), 0);
    check("async_done", 32'(done6), 0);
    check("async_len", 32'(len6), 0);
    check("async_ovf", 32'(ovf6), 0);
    check("async_rd_data", 32'(rd_data6), 0);
    check("async_busy3", 32'(busy3), 0);
    #1 rst_n = 1'b1;

    // After release: the upstream tail arrives as a new 3-beat packet.
    tick();
    arm6 = 1'b1;
    tick();
    arm6 = 1'b0;
    send(1'b0, 16'd3, 1'b0, 1'b0);
    send(1'b0, 16'd4, 1'b0, 1'b0);
    send(1'b0, 16'd5, 1'b1, 1'b0);
    check("tail_len", 32'(len6), 3);
    check("tail_done", 32'(done6), 1);
    check("tail_ovf", 32'(ovf6), 0);
    read6(6'd0, 16'd3);
    read6(6'd2, 16'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
